// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and a width helper for the register bank.
// No logic and no flow control; constants only.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/axi_regbank_dec.sv
// Address decoder: byte address -> register index plus hit and read-only flags.
// Latency: combinational. Backpressure: none.
module axi_regbank_dec
  import axi_lite_pkg::*;
#(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = 'h100,
  parameter int              NUM       = 8,
  parameter logic [NUM-1:0]  RO_MASK   = '0,
  parameter int              IW        = (NUM > 1) ? clog2(NUM) : 1
) (
  input  logic [AW-1:0] addr,
  output logic [IW-1:0] idx,
  output logic          hit,
  output logic          ro
);
  localparam int SHIFT = clog2(DW / 8);

  logic [AW-1:0] off;
  logic [AW-1:0] full_idx;

  // Sub-word address bits are dropped; the full-width index catches out-of-range offsets.
  assign off      = addr - BASE_ADDR;
  assign full_idx = off >> SHIFT;
  assign idx      = full_idx[IW-1:0];
  assign hit      = (addr >= BASE_ADDR) && (full_idx < AW'(NUM));
  assign ro       = hit && RO_MASK[idx];
endmodule

// File: rtl/axi_lite_regbank.sv
// AXI4-Lite register bank: NUM registers, byte strobes, read-only mask, decode errors.
// Latency: B two cycles after AW+W, R one cycle after AR. Backpressure: one B and one R outstanding, stall on bready/rready.
module axi_lite_regbank
  import axi_lite_pkg::*;
#(
  parameter int              AW        = 32,
  parameter int              DW        = 32,
  parameter logic [AW-1:0]   BASE_ADDR = 32'h0000_0100,
  parameter int              NUM       = 8,
  parameter logic [NUM-1:0]  RO_MASK   = '0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              awvalid,
  output logic              awready,
  input  logic [AW-1:0]     awaddr,
  input  logic              wvalid,
  output logic              wready,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wstrb,
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  input  logic              arvalid,
  output logic              arready,
  input  logic [AW-1:0]     araddr,
  output logic              rvalid,
  input  logic              rready,
  output logic [DW-1:0]     rdata,
  output logic [1:0]        rresp,
  input  logic [NUM*DW-1:0] ro_d,
  output logic [NUM*DW-1:0] reg_q,
  output logic [NUM-1:0]    wr_pulse
);
  localparam int SW = DW / 8;
  localparam int IW = (NUM > 1) ? clog2(NUM) : 1;

  logic          aw_full;
  logic          w_full;
  logic [AW-1:0] aw_addr_q;
  logic [DW-1:0] w_dat_q;
  logic [SW-1:0] w_strb_q;
  logic [DW-1:0] regs [NUM];
  logic [IW-1:0] w_idx;
  logic [IW-1:0] r_idx;
  logic          w_hit;
  logic          w_ro;
  logic          r_hit;
  logic          r_ro;
  logic          commit;
  logic          w_ok;

  axi_regbank_dec #(.AW(AW), .DW(DW), .BASE_ADDR(BASE_ADDR), .NUM(NUM), .RO_MASK(RO_MASK), .IW(IW))
    u_wdec (.addr(aw_addr_q), .idx(w_idx), .hit(w_hit), .ro(w_ro));

  axi_regbank_dec #(.AW(AW), .DW(DW), .BASE_ADDR(BASE_ADDR), .NUM(NUM), .RO_MASK(RO_MASK), .IW(IW))
    u_rdec (.addr(araddr), .idx(r_idx), .hit(r_hit), .ro(r_ro));

  assign awready = ~aw_full;
  assign wready  = ~w_full;
  assign arready = ~rvalid | rready;
  assign commit  = aw_full & w_full & (~bvalid | bready);
  assign w_ok    = w_hit & ~w_ro;

  // Write path: independent AW/W slots, commit once both are held and B is free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_dat_q   <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
    end else begin
      wr_pulse <= '0;
      if (awvalid && awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_full   <= 1'b1;
        w_dat_q  <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= !w_hit ? RESP_DECERR : (w_ro ? RESP_SLVERR : RESP_OKAY);
        if (w_ok) wr_pulse <= NUM'(1) << w_idx;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM; i++) regs[i] <= '0;
    end else if (commit && w_ok) begin
      for (int k = 0; k < SW; k++) begin
        if (w_strb_q[k]) regs[w_idx][8*k +: 8] <= w_dat_q[8*k +: 8];
      end
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_reg_q
    assign reg_q[g*DW +: DW] = regs[g];
  end

  // Read data is sampled from the registers before any same-edge write lands.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rresp  <= r_hit ? RESP_OKAY : RESP_DECERR;
      if (!r_hit)    rdata <= '0;
      else if (r_ro) rdata <= ro_d[r_idx*DW +: DW];
      else           rdata <= regs[r_idx];
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed bench for axi_lite_regbank (BASE 0x100, NUM 8, reg 7 read-only, DW 32).
`timescale 1ns/1ps
module tb_axi_lite_regbank;
  import axi_lite_pkg::*;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         awvalid = 1'b0;
  logic         awready;
  logic [31:0]  awaddr = '0;
  logic         wvalid = 1'b0;
  logic         wready;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         bvalid;
  logic         bready = 1'b0;
  logic [1:0]   bresp;
  logic         arvalid = 1'b0;
  logic         arready;
  logic [31:0]  araddr = '0;
  logic         rvalid;
  logic         rready = 1'b0;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic [255:0] ro_d = '0;
  logic [255:0] reg_q;
  logic [7:0]   wr_pulse;
  logic [255:0] snap;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  axi_lite_regbank #(
    .AW(32), .DW(32), .BASE_ADDR(32'h100), .NUM(8), .RO_MASK(8'h80)
  ) dut (
    .clk(clk), .rstn(rstn),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ro_d(ro_d), .reg_q(reg_q), .wr_pulse(wr_pulse)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present AW and/or W from a negedge; returns on the negedge after the last handshake.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input bit use_aw, input bit use_w);
    bit ag;
    bit wg;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = use_aw; wvalid = use_w;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      ag = awvalid && awready;
      wg = wvalid && wready;
      @(negedge clk);
      n++;
      if (ag) awvalid = 1'b0;
      if (wg) wvalid = 1'b0;
    end
    chk("wr_accept", {awvalid, wvalid}, 0);
    awvalid = 1'b0;
    wvalid = 1'b0;
  endtask

  task automatic wait_b(input string tag, input logic [1:0] exp);
    int n;
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_bvalid"}, bvalid, 1);
    chk({tag, "_bresp"}, bresp, exp);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
    int n;
    n = 0;
    araddr = a;
    arvalid = 1'b1;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    arvalid = 1'b0;
    chk({tag, "_rvalid"}, rvalid, 1);
    chk({tag, "_rdata"}, rdata, ed);
    chk({tag, "_rresp"}, rresp, er);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_reg_q", reg_q, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_ready", {awready, wready, arready}, 3'b111);

    // Basic write/read
    wr(32'h104, 32'h3456_789A, 4'hF, 1, 1);
    chk("wr1_bvalid_early", bvalid, 0);
    @(negedge clk);
    chk("wr1_pulse", wr_pulse, 8'h02);
    wait_b("wr1", RESP_OKAY);
    chk("wr1_pulse_clr", wr_pulse, 0);
    chk("wr1_bvalid_clr", bvalid, 0);
    chk("wr1_reg_q", reg_q[63:32], 32'h3456_789A);
    rd("rd1", 32'h104, 32'h3456_789A, RESP_OKAY);

    // Byte strobes, W well ahead of AW
    wr(32'h108, 32'h1122_3344, 4'hF, 1, 1);
    wait_b("bs_init", RESP_OKAY);
    wr(32'h0, 32'hAABB_CCDD, 4'b0101, 0, 1);
    repeat (2) begin
      chk("bs_no_b", bvalid, 0);
      chk("bs_wready_low", wready, 0);
      @(negedge clk);
    end
    wr(32'h108, 32'h0, 4'h0, 1, 0);
    chk("bs_b_after_aw", bvalid, 0);
    wait_b("bs", RESP_OKAY);
    chk("bs_reg2", reg_q[95:64], 32'h11BB_33DD);

    // Decode miss
    snap = reg_q;
    wr(32'h080, 32'hFFFF_FFFF, 4'hF, 1, 1);
    @(negedge clk);
    chk("miss_pulse", wr_pulse, 0);
    wait_b("miss", RESP_DECERR);
    chk("miss_reg_q", reg_q, snap);
    rd("miss_rd_lo", 32'h080, 32'h0, RESP_DECERR);
    rd("miss_rd_hi", 32'h120, 32'h0, RESP_DECERR);

    // Read-only register
    ro_d[255:224] = 32'hDEAD_BEEF;
    wr(32'h11C, 32'h1234_5678, 4'hF, 1, 1);
    @(negedge clk);
    chk("ro_pulse", wr_pulse, 0);
    wait_b("ro", RESP_SLVERR);
    chk("ro_reg_q", reg_q[255:224], 0);
    rd("ro_rd", 32'h11C, 32'hDEAD_BEEF, RESP_OKAY);

    // B backpressure with a second write queued in the slots
    wr(32'h100, 32'hA1A1_0001, 4'hF, 1, 1);
    wr(32'h10C, 32'hB2B2_0003, 4'hF, 1, 1);
    chk("bp_awready", awready, 0);
    chk("bp_wready", wready, 0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid_hold", bvalid, 1);
      chk("bp_bresp_hold", bresp, RESP_OKAY);
      chk("bp_reg3_stall", reg_q[127:96], 0);
      @(negedge clk);
    end
    chk("bp_reg0", reg_q[31:0], 32'hA1A1_0001);
    bready = 1'b1;
    @(negedge clk);
    chk("bp_b2_bvalid", bvalid, 1);
    chk("bp_b2_pulse", wr_pulse, 8'h08);
    chk("bp_b2_reg3", reg_q[127:96], 32'hB2B2_0003);
    @(negedge clk);
    bready = 1'b0;
    chk("bp_b2_done", bvalid, 0);

    // R backpressure holds rdata
    araddr = 32'h104;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rbp_rvalid", rvalid, 1);
      chk("rbp_rdata", rdata, 32'h3456_789A);
      chk("rbp_arready", arready, 0);
      @(negedge clk);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("rbp_done", rvalid, 0);

    // Asynchronous reset with B and R pending
    wr(32'h110, 32'h0000_0055, 4'hF, 1, 1);
    araddr = 32'h104;
    arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("arst_pre_b", bvalid, 1);
    chk("arst_pre_r", rvalid, 1);
    #1 rstn = 1'b0;
    #1;
    chk("arst_bvalid", bvalid, 0);
    chk("arst_rvalid", rvalid, 0);
    chk("arst_reg_q", reg_q, 0);
    chk("arst_ready", {awready, wready, arready}, 3'b111);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rd("arst_rd", 32'h104, 32'h0, RESP_OKAY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
